icache_assoc: RTL
=================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, word width (2-byte words).
REQ-003 The block SHALL have parameter SET_BITS, default 6, log2 of the set count.
REQ-004 The block SHALL have parameter WORD_BITS, default 3, log2 of words per line.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  reset
- cpu_req  in  1  fetch request
- cpu_addr  in  ADDR_W  fetch byte address
- cpu_rdata  out  DATA_W  fetched word
- cpu_valid  out  1  cpu_rdata valid (hit)
- cpu_stall  out  1  CPU must hold cpu_req/cpu_addr
- flush  in  1  invalidate-all pulse
- mem_req  out  1  refill word request
- mem_addr  out  ADDR_W  refill word address
- mem_rdata  in  DATA_W  refill data
- mem_rvalid  in  1  refill word accepted/returned

Function
REQ-007 Address split SHALL be: offset = addr[WORD_BITS:1]; set = addr[SET_BITS+WORD_BITS:WORD_BITS+1]; tag = upper ADDR_W-SET_BITS-WORD_BITS-1 bits; addr[0] ignored.
REQ-008 Organisation SHALL be 2-way set-associative, per-set one LRU bit, per-way valid+tag+line.
REQ-009 Lookup SHALL be combinational in IDLE: hit = cpu_req and valid and tag match in either way; cpu_valid and cpu_rdata in the same cycle.
REQ-010 On a hit the LRU bit SHALL be updated at the clock edge so the other way becomes LRU.
REQ-011 FSM states SHALL be IDLE, FILL, DONE, FLUSH.
REQ-012 IDLE -> FILL on cpu_req miss; victim = invalid way (way0 first), else LRU way; victim and line address latched.
REQ-013 In FILL, mem_req SHALL be 1 with mem_addr = line base + 2*count; each mem_rvalid writes mem_rdata into victim word count and increments count.
REQ-014 After the last word FILL -> DONE, writing tag, valid=1, victim MRU; DONE -> IDLE unconditionally.
REQ-015 cpu_stall SHALL be 1 when state != IDLE, or when IDLE with cpu_req and miss; cpu_valid SHALL be 0 whenever state != IDLE.
REQ-016 mem_rvalid outside FILL SHALL be ignored.
REQ-017 flush in IDLE SHALL enter FLUSH, clearing valid and LRU of one set per cycle, set 0 upward, 2^SET_BITS cycles, then IDLE.
REQ-018 flush during FILL/DONE SHALL be latched pending and FLUSH SHALL start from IDLE after DONE, before any lookup.
REQ-019 flush and a miss in the same IDLE cycle: flush SHALL win; no refill starts.

Reset
REQ-020 Reset SHALL clear all valid and LRU bits, state = IDLE, counters and pending flush to 0.
REQ-021 During reset all outputs SHALL be 0; data/tag storage is not reset.
REQ-022 Reset mid-FILL SHALL abort: mem_req 0 from the next cycle, partial line left invalid.

Structure
REQ-023 Package icache_pkg SHALL hold the state enum and default parameter constants.
REQ-024 One sub-module icache_way (valid/tag/data storage, async read, sync write) SHALL be instantiated twice.

Verification
REQ-025 Cold miss: read 0x1234 (set 0x23, tag 0x04, offset 2), memory returns 0xA000+i each cycle -> mem_addr 0x1230..0x123E, cpu_stall 10 cycles, then cpu_valid with cpu_rdata 0xA002.
REQ-026 Replacement: fill 0x0000, 0x0400, re-read 0x0000 (hit), read 0x0800 -> way holding 0x0400 evicted; 0x0400 then misses, 0x0000 hits.
REQ-027 Flush: after REQ-025, pulse flush -> cpu_stall 64 cycles, then 0x1234 misses.
REQ-028 Flush during fill with 3-cycle mem_rvalid gaps -> fill completes, then 64-cycle FLUSH, then 0x1234 misses.
REQ-029 Reset at the 4th refill word -> mem_req 0 next cycle, 0x1234 misses after reset.
REQ-030 SET_BITS=4, WORD_BITS=2 instance: read 0x0106 -> 4-word fill 0x0100..0x0106, second read hits.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the two-way set-associative instruction cache.
// Holds the controller state encoding, the default geometry constants used
// by the interface and modules, and a small LRU helper.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int SET_BITS_DEF  = 6;
  localparam int WORD_BITS_DEF = 3;

  // With two ways, the LRU way after touching 'way' is simply the other one.
  function automatic logic other_way(input logic way);
    return !way;
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Bus bundle between a fetch unit, the instruction cache and the refill memory.
//   CPU side : cpu_req, cpu_addr -> cache ; cpu_rdata, cpu_valid, cpu_stall <- cache
//   control  : flush (invalidate-all pulse) -> cache
//   refill   : mem_req, mem_addr <- cache ; mem_rdata, mem_rvalid -> cache
// modport slave  : the cache itself
// modport master : the environment (fetch unit + memory)
interface icache_assoc_if import icache_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_valid;
  logic              cpu_stall;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_rdata, mem_rvalid,
    output cpu_rdata, cpu_valid, cpu_stall, mem_req, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_rdata, mem_rvalid,
    input  cpu_rdata, cpu_valid, cpu_stall, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_way.sv
// One way of the cache: per-set valid bit, tag and line storage.
// Reads are asynchronous (lookup happens in the same cycle as the request);
// writes are synchronous. Only the valid bits are reset; tag and line
// storage keep whatever they held.
//   rd_set/rd_word   : lookup index -> rd_valid, rd_tag, rd_data
//   word_we          : write wr_data into word wr_word of set wr_set
//   tag_we           : write wr_tag for set wr_set and mark it valid
//   inv_en/inv_set   : clear the valid bit of one set
module icache_way import icache_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_W     = ADDR_W_DEF - SET_BITS_DEF - WORD_BITS_DEF - 1,
  parameter int SET_BITS  = SET_BITS_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_BITS-1:0]  rd_set,
  input  logic [WORD_BITS-1:0] rd_word,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [DATA_W-1:0]    rd_data,
  input  logic                 word_we,
  input  logic [SET_BITS-1:0]  wr_set,
  input  logic [WORD_BITS-1:0] wr_word,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 tag_we,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 inv_en,
  input  logic [SET_BITS-1:0]  inv_set
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int DEPTH = 1 << (SET_BITS + WORD_BITS);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [DEPTH];

  assign rd_valid = valid[rd_set];
  assign rd_tag   = tag_mem[rd_set];
  assign rd_data  = data_mem[{rd_set, rd_word}];

  // Invalidate is applied after validate so it wins if both ever coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (tag_we) valid[wr_set]  <= 1'b1;
      if (inv_en) valid[inv_set] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we)  tag_mem[wr_set]             <= wr_tag;
    if (word_we) data_mem[{wr_set, wr_word}] <= wr_data;
  end

endmodule

// File: rtl/icache_assoc.sv
// Two-way set-associative instruction cache with LRU replacement.
// Lookup is combinational in IDLE; a miss refills the whole line one word at
// a time from memory (FILL), commits tag/valid (DONE) and returns to IDLE.
// A flush clears valid and LRU bits one set per cycle (FLUSH); a flush seen
// while a refill is in flight is remembered and serviced right after it.
//   clk, rst : clock, synchronous active-high reset (all outputs 0 in reset)
//   bus      : icache_assoc_if.slave (CPU fetch port, flush, refill port)
module icache_assoc import icache_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SET_BITS  = SET_BITS_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  icache_assoc_if.slave bus
);

  localparam int LINE_W = ADDR_W - WORD_BITS - 1;  // tag + set
  localparam int TAG_W  = LINE_W - SET_BITS;
  localparam int SETS   = 1 << SET_BITS;

  state_t               state;
  logic [WORD_BITS-1:0] count;
  logic [SET_BITS-1:0]  flush_cnt;
  logic                 flush_pend;
  logic [SETS-1:0]      lru;        // per set: index of the least recently used way
  logic                 victim;
  logic [LINE_W-1:0]    line_addr;

  logic [WORD_BITS-1:0] cpu_word;
  logic [SET_BITS-1:0]  cpu_set;
  logic [TAG_W-1:0]     cpu_tag;
  logic                 addr_lsb_unused;
  logic [SET_BITS-1:0]  fill_set;
  logic [TAG_W-1:0]     fill_tag;

  logic [1:0]              way_valid;
  logic [1:0][TAG_W-1:0]   way_tag;
  logic [1:0][DATA_W-1:0]  way_data;
  logic [1:0]              way_hit;
  logic                    any_hit;
  logic                    lookup_hit;
  logic                    idle;
  logic                    flushing;
  logic                    go_flush;
  logic                    start_fill;
  logic                    fill_we;
  logic                    fill_last;
  logic                    victim_sel;
  logic [SET_BITS-1:0]     inv_set;
  logic                    hit_valid;
  logic                    fetch_active;

  // Byte address split; bit 0 is ignored because fetches are word-aligned.
  assign cpu_word        = bus.cpu_addr[WORD_BITS:1];
  assign cpu_set         = bus.cpu_addr[SET_BITS+WORD_BITS:WORD_BITS+1];
  assign cpu_tag         = bus.cpu_addr[ADDR_W-1:SET_BITS+WORD_BITS+1];
  assign addr_lsb_unused = bus.cpu_addr[0];
  assign fill_set        = line_addr[SET_BITS-1:0];
  assign fill_tag        = line_addr[LINE_W-1:SET_BITS];

  assign idle     = (state == ST_IDLE);
  assign flushing = (state == ST_FLUSH);

  assign way_hit[0] = way_valid[0] && (way_tag[0] == cpu_tag);
  assign way_hit[1] = way_valid[1] && (way_tag[1] == cpu_tag);
  assign any_hit    = |way_hit;

  // A pending flush must run before any further lookup, so it masks hits.
  assign lookup_hit = any_hit && !flush_pend;
  assign go_flush   = idle && (bus.flush || flush_pend);
  assign start_fill = idle && bus.cpu_req && !any_hit && !bus.flush && !flush_pend;
  assign fill_we    = (state == ST_FILL) && bus.mem_rvalid;
  assign fill_last  = fill_we && (&count);
  assign inv_set    = flushing ? flush_cnt : cpu_set;

  // Prefer an empty way (way 0 first); otherwise evict the LRU way.
  always_comb begin
    victim_sel = lru[cpu_set];
    if (!way_valid[0]) begin
      victim_sel = 1'b0;
    end else if (!way_valid[1]) begin
      victim_sel = 1'b1;
    end
  end

  for (genvar w = 0; w < 2; w++) begin : g_way
    logic is_victim;
    logic inv_way;
    assign is_victim = (victim == 1'(w));
    // The victim line is dropped as soon as its refill starts, so an aborted
    // refill can never leave a half-written line marked valid.
    assign inv_way   = flushing || (start_fill && (victim_sel == 1'(w)));

    icache_way #(
      .DATA_W    (DATA_W),
      .TAG_W     (TAG_W),
      .SET_BITS  (SET_BITS),
      .WORD_BITS (WORD_BITS)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_set   (cpu_set),
      .rd_word  (cpu_word),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_data  (way_data[w]),
      .word_we  (fill_we && is_victim),
      .wr_set   (fill_set),
      .wr_word  (count),
      .wr_data  (bus.mem_rdata),
      .tag_we   (fill_last && is_victim),
      .wr_tag   (fill_tag),
      .inv_en   (inv_way),
      .inv_set  (inv_set)
    );
  end

  // Controller: state, refill word counter, flush sweep counter, LRU bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
      lru        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go_flush) begin
            state      <= ST_FLUSH;
            flush_pend <= 1'b0;
          end else if (start_fill) begin
            state <= ST_FILL;
          end else if (bus.cpu_req && lookup_hit) begin
            lru[cpu_set] <= other_way(!way_hit[0]);
          end
        end
        ST_FILL: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (bus.mem_rvalid) begin
            count <= count + 1'b1;
            if (&count) begin
              state         <= ST_DONE;
              lru[fill_set] <= other_way(victim);
            end
          end
        end
        ST_DONE: begin
          if (bus.flush) flush_pend <= 1'b1;
          state <= ST_IDLE;
        end
        ST_FLUSH: begin
          lru[flush_cnt] <= 1'b0;
          flush_cnt      <= flush_cnt + 1'b1;
          if (&flush_cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Refill target, captured on the miss that starts the refill.
  always_ff @(posedge clk) begin
    if (start_fill) begin
      victim    <= victim_sel;
      line_addr <= bus.cpu_addr[ADDR_W-1:WORD_BITS+1];
    end
  end

  assign hit_valid    = !rst && idle && bus.cpu_req && lookup_hit;
  assign fetch_active = !rst && (state == ST_FILL);

  assign bus.cpu_valid = hit_valid;
  assign bus.cpu_rdata = hit_valid ? (way_hit[0] ? way_data[0] : way_data[1]) : '0;
  assign bus.cpu_stall = !rst && (!idle || (bus.cpu_req && !lookup_hit));
  assign bus.mem_req   = fetch_active;
  assign bus.mem_addr  = fetch_active ? {line_addr, count, 1'b0} : '0;

endmodule
